// File: rtl/sat_accum_ctrl_pkg.sv
// sat_accum_ctrl_pkg: shared FSM state and accumulation mode encodings
package sat_accum_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic MODE_SIGNED = 1'b0;
    localparam logic MODE_UNSIGNED = 1'b1;
endpackage

// File: rtl/no_overflow_adder.sv
// no_overflow_adder: signed two's-complement adder clamping to the signed range
module no_overflow_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             po,
    output logic             no
);
    logic [WIDTH-1:0] raw;
    always_comb begin
        raw = a + b;
        po = !a[WIDTH-1] && !b[WIDTH-1] && raw[WIDTH-1];
        no = a[WIDTH-1] && b[WIDTH-1] && !raw[WIDTH-1];
        sum = po ? {1'b0, {(WIDTH-1){1'b1}}} : no ? {1'b1, {(WIDTH-1){1'b0}}} : raw;
    end
endmodule

// File: rtl/no_overflow_unsig_adder.sv
// no_overflow_unsig_adder: unsigned accumulator plus signed delta, optional clamp to [0, 2^W-1]
module no_overflow_unsig_adder #(
    parameter int WIDTH = 32,
    parameter bit ALLOW_PO = 1'b0,
    parameter bit ALLOW_NO = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             po,
    output logic             no
);
    logic [WIDTH+1:0] ext;
    always_comb begin
        ext = {2'b00, a} + {{2{b[WIDTH-1]}}, b};
        po = !ext[WIDTH+1] && ext[WIDTH];
        no = ext[WIDTH+1];
        sum = (po && !ALLOW_PO) ? '1 : (no && !ALLOW_NO) ? '0 : ext[WIDTH-1:0];
    end
endmodule

// File: rtl/sat_accum_ctrl.sv
// sat_accum_ctrl: streams len operands into a saturating accumulator and hands off the result
module sat_accum_ctrl
    import sat_accum_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_po,
    output logic             out_no
);
    state_t state, state_n;
    logic [WIDTH-1:0] acc, s_sum, u_sum, add_sum;
    logic [CNT_W-1:0] cnt;
    logic po_f, no_f, mode_r, s_po, s_no, u_po, u_no, add_po, add_no, hs;

    no_overflow_adder #(.WIDTH(WIDTH)) u_sadd (
        .a(acc), .b(in_data), .sum(s_sum), .po(s_po), .no(s_no)
    );

    no_overflow_unsig_adder #(.WIDTH(WIDTH), .ALLOW_PO(1'b0), .ALLOW_NO(1'b0)) u_uadd (
        .a(acc), .b(in_data), .sum(u_sum), .po(u_po), .no(u_no)
    );

    always_comb begin
        add_sum = (mode_r == MODE_UNSIGNED) ? u_sum : s_sum;
        add_po = (mode_r == MODE_UNSIGNED) ? u_po : s_po;
        add_no = (mode_r == MODE_UNSIGNED) ? u_no : s_no;
        busy = state != IDLE;
        in_ready = state == ACCUM && !abort;
        hs = in_valid && in_ready;
        out_valid = state == DONE;
        out_data = out_valid ? acc : '0;
        out_po = out_valid && po_f;
        out_no = out_valid && no_f;
        // abort outranks every handshake, including start and out_ready
        state_n = abort ? IDLE
                : state == IDLE ? (start ? (len != '0 ? ACCUM : DONE) : IDLE)
                : state == ACCUM ? ((hs && cnt == CNT_W'(1)) ? DONE : ACCUM)
                : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            po_f <= 1'b0;
            no_f <= 1'b0;
            mode_r <= MODE_SIGNED;
        end else begin
            state <= state_n;
            if (state == IDLE && start && !abort) begin
                acc <= '0;
                cnt <= len;
                po_f <= 1'b0;
                no_f <= 1'b0;
                mode_r <= mode;
            end else if (hs) begin
                acc <= add_sum;
                cnt <= cnt - 1'b1;
                po_f <= po_f | add_po;
                no_f <= no_f | add_no;
            end
        end
    end
endmodule

// File: tb/tb_sat_accum_ctrl.sv
// tb_sat_accum_ctrl: directed vectors for sat_accum_ctrl at WIDTH = 8
module tb_sat_accum_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] len = '0, in_data = '0;
    logic busy, in_ready, out_valid, out_po, out_no;
    logic [7:0] out_data;
    int n_cmp = 0, n_err = 0;

    sat_accum_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .abort(abort),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_po(out_po), .out_no(out_no)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l, input logic m);
        @(negedge clk);
        start = 1'b1;
        len = l;
        mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        chk("in_ready_before_feed", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [7:0] d, input logic po, input logic no);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_po"}, out_po, po);
        chk({tag, "_no"}, out_no, no);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_cleared"}, {out_valid, out_data, out_po, out_no}, 0);
    endtask

    initial begin
        #12;
        chk("rst_outputs", {busy, in_ready, out_valid, out_data, out_po, out_no}, 0);
        @(negedge clk);
        rst = 1'b0;

        do_start(8'd3, 1'b0);
        feed(8'd100);
        feed(8'd50);
        chk("s_not_done_early", out_valid, 0);
        feed(8'hEC);
        result("signed_pos", 8'd107, 1'b1, 1'b0);

        do_start(8'd2, 1'b0);
        feed(8'h9C);
        feed(8'h9C);
        result("signed_neg", 8'h80, 1'b0, 1'b1);

        do_start(8'd3, 1'b1);
        feed(8'd100);
        feed(8'd100);
        feed(8'd100);
        result("unsig_pos", 8'hFF, 1'b1, 1'b0);

        do_start(8'd1, 1'b1);
        feed(8'h80);
        result("unsig_neg", 8'h00, 1'b0, 1'b1);

        chk("len0_pre", out_valid, 0);
        do_start(8'd0, 1'b0);
        result("len0", 8'h00, 1'b0, 1'b0);

        do_start(8'd1, 1'b0);
        feed(8'd5);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len = 8'd2;
            chk("hold_data", {busy, out_valid, out_data, out_po, out_no}, {2'b11, 8'd5, 2'b00});
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_idle", {busy, in_ready, out_valid}, 0);

        do_start(8'd4, 1'b0);
        feed(8'd10);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd20;
        #1;
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_idle", {busy, in_ready, out_valid}, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_result", {busy, out_valid}, 0);

        do_start(8'd3, 1'b0);
        feed(8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_accum", {busy, in_ready, out_valid, out_data, out_po, out_no}, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        len = 8'd1;
        mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_rst", busy, 1);
        feed(8'd7);
        result("post_rst", 8'd7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sat_accum_ctrl.md
SAT_ACCUM_CTRL -- requirements
Module: sat_accum_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and accumulator width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the operand-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a new accumulation.
REQ-006 SHALL have port len, input, CNT_W bits: number of operands to accumulate; sampled when start is accepted.
REQ-007 SHALL have port mode, input, 1 bit: sampled when start is accepted; 0 = signed saturation, 1 = unsigned accumulator with signed operand delta.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the current operation.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: block accepts in_data.
REQ-012 SHALL have port in_data, input, WIDTH bits: operand.
REQ-013 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port out_data, output, WIDTH bits: accumulated result.
REQ-016 SHALL have port out_po, output, 1 bit: sticky flag; at least one add clamped to the positive limit.
REQ-017 SHALL have port out_no, output, 1 bit: sticky flag; at least one add clamped to the negative limit (signed) or to zero (unsigned).

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-019 SHALL, in IDLE, accept start: clear acc, cnt and flags, and latch len and mode; go to ACCUM if len != 0, else to DONE.
REQ-020 SHALL ignore start while busy = 1.
REQ-021 SHALL drive in_ready = 1 only in ACCUM with abort = 0.
REQ-022 SHALL, on an in_valid && in_ready handshake, update acc to the saturating sum of acc and in_data, OR the add's PO/NO into the sticky flags, and decrement the remaining count.
REQ-023 SHALL, in signed mode, clamp to 2^(W-1)-1 on positive overflow and to -2^(W-1) on negative overflow.
REQ-024 SHALL, in unsigned mode, treat acc as unsigned and in_data as a signed delta, clamping to [0, 2^W-1].
REQ-025 SHALL go from ACCUM to DONE on the handshake that consumes the last operand; out_valid SHALL rise the next cycle (1-cycle latency).
REQ-026 SHALL, in DONE, hold out_valid = 1 and keep out_data, out_po and out_no stable until out_ready = 1, then return to IDLE.
REQ-027 SHALL drive out_data, out_po and out_no to 0 whenever out_valid = 0.
REQ-028 SHALL, when abort = 1 in any state, go to IDLE on the next edge with no output and no operand consumed that cycle; abort has priority over every handshake.
REQ-029 SHALL, for len = 0, go to DONE with result 0 and both flags 0.
REQ-030 SHALL tolerate in_valid in IDLE or DONE without consuming it.

Reset
REQ-031 SHALL, on rst asserted asynchronously (including mid-operation), return to IDLE with acc, cnt, flags, busy, in_ready and out_valid = 0.
REQ-032 SHALL be able to accept start on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL define the FSM state encoding and the mode encodings (MODE_SIGNED = 0, MODE_UNSIGNED = 1) in the shared package.
REQ-034 SHALL instantiate the existing no_overflow_adder (signed) and no_overflow_unsig_adder (ALLOW_PO = 0, ALLOW_NO = 0), selected by the latched mode; no new sub-module.
REQ-035 SHALL have exactly one WIDTH adder path per mode and no combinational path from in_data to out_data.

Verification (WIDTH = 8)
REQ-036 SHALL cover: signed, len = 3, data 100, 50, -20 -> out_data = 107, out_po = 1, out_no = 0.
REQ-037 SHALL cover: unsigned, len = 3, data 100, 100, 100 -> out_data = 255, out_po = 1; then len = 1, data 0x80 after reset of acc -> out_data = 0, out_no = 1.
REQ-038 SHALL cover: len = 0 -> out_valid next cycle with out_data = 0 and both flags 0.
REQ-039 SHALL cover: out_ready held low 5 cycles, start pulsed -> outputs stable, start ignored, IDLE one cycle after out_ready.
REQ-040 SHALL cover: abort after 1 of 4 operands -> IDLE next cycle, in_ready = 0, no out_valid.
REQ-041 SHALL cover: rst asserted mid-ACCUM -> all outputs 0 immediately; a new start is accepted on the first edge after release.
